// File: rtl/axi_ic_ar_arb.sv
// axi_ic_ar_arb: per-slave AR-channel round-robin arbiter with a one-entry
// output slice, master-index ARID prefixing and an outstanding-burst cap
// driven by the slave's R-channel last-beat handshakes.
module axi_ic_ar_arb #(
  parameter int NumMasters     = 2,
  parameter int IdWidth        = 8,
  parameter int AddrWidth      = 32,
  parameter int MaxOutstanding = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumMasters-1:0]                m_arvalid_i,
  output logic [NumMasters-1:0]                m_arready_o,
  input  logic [NumMasters*(IdWidth/2)-1:0]    m_arid_i,
  input  logic [NumMasters*AddrWidth-1:0]      m_araddr_i,
  input  logic [NumMasters*8-1:0]              m_arlen_i,
  output logic                                 s_arvalid_o,
  input  logic                                 s_arready_i,
  output logic [IdWidth-1:0]                   s_arid_o,
  output logic [AddrWidth-1:0]                 s_araddr_o,
  output logic [7:0]                           s_arlen_o,
  input  logic                                 s_rvalid_i,
  input  logic                                 s_rready_i,
  input  logic                                 s_rlast_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 err_o
);

  localparam int HalfId = IdWidth / 2;
  localparam int CntW   = $clog2(MaxOutstanding + 1);
  localparam int IdxW   = (NumMasters > 1) ? $clog2(NumMasters) : 1;

  // Parameter sanity: the master index must fit in the upper ARID half.
  if (NumMasters > (2 ** (IdWidth / 2))) begin : g_chk_masters
    $error("axi_ic_ar_arb: NumMasters does not fit in IdWidth/2 bits");
  end
  if ((IdWidth % 2) != 0) begin : g_chk_idw
    $error("axi_ic_ar_arb: IdWidth must be even");
  end
  if (MaxOutstanding < 1) begin : g_chk_max
    $error("axi_ic_ar_arb: MaxOutstanding must be at least 1");
  end

  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 arvalid_q, arvalid_d;
  logic [IdWidth-1:0]   arid_q, arid_d;
  logic [AddrWidth-1:0] araddr_q, araddr_d;
  logic [7:0]           arlen_q, arlen_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic                 slot_free_s;
  logic                 accept_s;
  logic                 dec_s;
  logic                 found_s;
  logic [IdxW-1:0]      winner_s;
  logic [HalfId-1:0]    winner_ext_s;

  // Round-robin search: first requester at or above rr_ptr, wrapping.
  always_comb begin
    logic [IdxW:0] cand;
    found_s  = 1'b0;
    winner_s = rr_ptr_q;
    for (int i = 0; i < NumMasters; i++) begin
      cand = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
      if (cand >= (IdxW+1)'(NumMasters)) begin
        cand = cand - (IdxW+1)'(NumMasters);
      end else begin
        cand = cand;
      end
      if (!found_s && m_arvalid_i[cand[IdxW-1:0]]) begin
        found_s  = 1'b1;
        winner_s = cand[IdxW-1:0];
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Accept decision and one-hot master ready; no credit look-ahead on a
  // same-cycle completion, so a full counter blocks for this whole cycle.
  always_comb begin
    slot_free_s = !arvalid_q || s_arready_i;
    accept_s    = slot_free_s && (cnt_q < CntW'(MaxOutstanding)) &&
                  (|m_arvalid_i) && !rst_i;
    dec_s       = s_rvalid_i && s_rready_i && s_rlast_i;
    m_arready_o = '0;
    if (accept_s) begin
      m_arready_o[winner_s] = 1'b1;
    end else begin
      m_arready_o = '0;
    end
  end

  // Next state for the output slice, round-robin pointer, counter and error.
  always_comb begin
    winner_ext_s = HalfId'(winner_s);
    rr_ptr_d  = rr_ptr_q;
    arvalid_d = arvalid_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    cnt_d     = cnt_q;
    err_d     = err_q;

    if (accept_s) begin
      arvalid_d = 1'b1;
      arid_d    = {winner_ext_s, m_arid_i[winner_s*HalfId +: HalfId]};
      araddr_d  = m_araddr_i[winner_s*AddrWidth +: AddrWidth];
      arlen_d   = m_arlen_i[winner_s*8 +: 8];
      if (winner_s == IdxW'(NumMasters - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = winner_s + IdxW'(1);
      end
    end else if (arvalid_q && s_arready_i) begin
      arvalid_d = 1'b0;
    end else begin
      arvalid_d = arvalid_q;
    end

    case ({accept_s, dec_s})
      2'b10: cnt_d = cnt_q + CntW'(1);
      2'b01: begin
        if (cnt_q == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers with synchronous reset; reset drops any buffered request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q  <= '0;
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= 8'd0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      arvalid_q <= arvalid_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign s_arvalid_o   = arvalid_q;
  assign s_arid_o      = arid_q;
  assign s_araddr_o    = araddr_q;
  assign s_arlen_o     = arlen_q;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_axi_ic_ar_arb.sv
// Directed testbench for axi_ic_ar_arb with default parameters.
module tb_axi_ic_ar_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_arvalid;
  logic [1:0]  m_arready;
  logic [7:0]  m_arid;
  logic [63:0] m_araddr;
  logic [15:0] m_arlen;
  logic        s_arvalid;
  logic        s_arready;
  logic [7:0]  s_arid;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic        s_rvalid, s_rready, s_rlast;
  logic [2:0]  outstanding;
  logic        err;

  int tests = 0;
  int fails = 0;

  axi_ic_ar_arb dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .m_arvalid_i   (m_arvalid),
    .m_arready_o   (m_arready),
    .m_arid_i      (m_arid),
    .m_araddr_i    (m_araddr),
    .m_arlen_i     (m_arlen),
    .s_arvalid_o   (s_arvalid),
    .s_arready_i   (s_arready),
    .s_arid_o      (s_arid),
    .s_araddr_o    (s_araddr),
    .s_arlen_o     (s_arlen),
    .s_rvalid_i    (s_rvalid),
    .s_rready_i    (s_rready),
    .s_rlast_i     (s_rlast),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rlast(input logic v);
    s_rvalid = v;
    s_rready = v;
    s_rlast  = v;
  endtask

  initial begin
    rst = 1'b1; m_arvalid = 2'b00; m_arid = 8'h00; m_araddr = 64'h0;
    m_arlen = 16'h0; s_arready = 1'b0; rlast(1'b0);
    step();
    // Ready must stay low while reset is asserted, even with a request.
    m_arvalid = 2'b01;
    #1 chk("rst_ready", 64'(m_arready), 64'h0);
    step();
    chk("rst_valid", 64'(s_arvalid), 64'h0);
    chk("rst_arid", 64'(s_arid), 64'h0);
    chk("rst_addr", 64'(s_araddr), 64'h0);
    chk("rst_len", 64'(s_arlen), 64'h0);
    chk("rst_cnt", 64'(outstanding), 64'h0);
    chk("rst_err", 64'(err), 64'h0);

    // Single request from master 0.
    rst = 1'b0; m_arvalid = 2'b01; m_arid = 8'h05; m_araddr = {32'h0, 32'h1000};
    m_arlen = {8'd0, 8'd3}; s_arready = 1'b1;
    #1 chk("t1_ready", 64'(m_arready), 64'h1);
    step();
    chk("t1_valid", 64'(s_arvalid), 64'h1);
    chk("t1_arid", 64'(s_arid), 64'h05);
    chk("t1_addr", 64'(s_araddr), 64'h1000);
    chk("t1_len", 64'(s_arlen), 64'h3);
    chk("t1_cnt", 64'(outstanding), 64'h1);

    // Both masters requesting, rlast every cycle: grants alternate from ptr=1.
    m_arvalid = 2'b11; m_arid = {4'h3, 4'hA}; m_araddr = {32'h3000, 32'h2000};
    m_arlen = {8'd2, 8'd1}; rlast(1'b1);
    #1 chk("rr_a_ready", 64'(m_arready), 64'h2);
    step();
    chk("rr_a_arid", 64'(s_arid), 64'h13);
    chk("rr_a_addr", 64'(s_araddr), 64'h3000);
    chk("rr_a_len", 64'(s_arlen), 64'h2);
    chk("rr_a_cnt", 64'(outstanding), 64'h1);
    #1 chk("rr_b_ready", 64'(m_arready), 64'h1);
    step();
    chk("rr_b_arid", 64'(s_arid), 64'h0A);
    chk("rr_b_addr", 64'(s_araddr), 64'h2000);
    #1 chk("rr_c_ready", 64'(m_arready), 64'h2);
    step();
    chk("rr_c_arid", 64'(s_arid), 64'h13);
    #1 chk("rr_d_ready", 64'(m_arready), 64'h1);
    step();
    chk("rr_d_arid", 64'(s_arid), 64'h0A);
    chk("rr_d_cnt", 64'(outstanding), 64'h1);

    // Backpressure: slice holds master-0 request for 5 cycles.
    s_arready = 1'b0; rlast(1'b0);
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_ready", 64'(m_arready), 64'h0);
      step();
      chk("bp_valid", 64'(s_arvalid), 64'h1);
      chk("bp_arid", 64'(s_arid), 64'h0A);
      chk("bp_addr", 64'(s_araddr), 64'h2000);
    end
    s_arready = 1'b1;
    #1 chk("bp_rel_ready", 64'(m_arready), 64'h2);
    step();
    chk("bp_rel_arid", 64'(s_arid), 64'h13);
    chk("bp_rel_cnt", 64'(outstanding), 64'h2);

    // Accept and completion in the same cycle at count 2.
    rlast(1'b1);
    #1 chk("same_ready", 64'(m_arready), 64'h1);
    step();
    chk("same_cnt", 64'(outstanding), 64'h2);
    chk("same_arid", 64'(s_arid), 64'h0A);

    // Fill to the limit without completions.
    rlast(1'b0);
    #1 chk("fill3_ready", 64'(m_arready), 64'h2);
    step();
    chk("fill3_cnt", 64'(outstanding), 64'h3);
    #1 chk("fill4_ready", 64'(m_arready), 64'h1);
    step();
    chk("fill4_cnt", 64'(outstanding), 64'h4);
    m_arvalid = 2'b01;
    #1 chk("full_ready", 64'(m_arready), 64'h0);
    step();
    chk("full_drain_valid", 64'(s_arvalid), 64'h0);
    chk("full_cnt", 64'(outstanding), 64'h4);
    rlast(1'b1);
    #1 chk("full_nolook", 64'(m_arready), 64'h0);
    step();
    chk("dec_cnt", 64'(outstanding), 64'h3);
    rlast(1'b0);
    #1 chk("resume_ready", 64'(m_arready), 64'h1);
    step();
    chk("resume_cnt", 64'(outstanding), 64'h4);
    chk("resume_valid", 64'(s_arvalid), 64'h1);
    chk("resume_arid", 64'(s_arid), 64'h0A);

    // Buffered request plus count 3, then reset mid-operation.
    m_arvalid = 2'b00; s_arready = 1'b0; rlast(1'b1);
    step();
    chk("pre_rst_cnt", 64'(outstanding), 64'h3);
    chk("pre_rst_valid", 64'(s_arvalid), 64'h1);
    rst = 1'b1; rlast(1'b0); m_arvalid = 2'b11;
    #1 chk("mid_rst_ready", 64'(m_arready), 64'h0);
    step();
    chk("mid_rst_valid", 64'(s_arvalid), 64'h0);
    chk("mid_rst_cnt", 64'(outstanding), 64'h0);
    rst = 1'b0; s_arready = 1'b1;
    #1 chk("mid_rst_ptr", 64'(m_arready), 64'h1);
    step();
    chk("post_rst_cnt", 64'(outstanding), 64'h1);
    chk("post_rst_arid", 64'(s_arid), 64'h0A);

    // Underflow: drain to 0, then one extra completion sets sticky err.
    m_arvalid = 2'b00; rlast(1'b1);
    step();
    chk("uf_cnt0", 64'(outstanding), 64'h0);
    chk("uf_err0", 64'(err), 64'h0);
    step();
    chk("uf_cnt", 64'(outstanding), 64'h0);
    chk("uf_err", 64'(err), 64'h1);
    rlast(1'b0);
    step();
    chk("uf_sticky", 64'(err), 64'h1);
    rst = 1'b1;
    step();
    chk("uf_rst_err", 64'(err), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
